// File: rtl/gmii_tx_sched_pkg.sv
// Shared scheduler definitions: FSM state codes, packet-class select values
// and the packet ident bytes the frame builder expects for each class.
// Latency: n/a (declarations only). Backpressure: n/a.
package gmii_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_HOLDOFF   = 2'd2
  } state_t;

  // pkt_sel encoding
  localparam logic SEL_VIDEO = 1'b0;
  localparam logic SEL_AUDIO = 1'b1;

  // Ident bytes placed in the frame header by the builder
  localparam logic [7:0] PKT_IDENT_VIDEO = 8'h00;
  localparam logic [7:0] PKT_IDENT_AUDIO = 8'h01;

  function automatic logic [7:0] sel_to_ident(input logic sel);
    return (sel == SEL_AUDIO) ? PKT_IDENT_AUDIO : PKT_IDENT_VIDEO;
  endfunction

endpackage

// File: rtl/gmii_tx_sched_stats.sv
// Saturating grant/timeout statistics counters for the tx scheduler.
// Latency: counters reflect an increment one cycle after the strobe.
// Backpressure: none; clr zeroes all counters and wins over increments.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   clr                 synchronous clear of all counters
//   vid_inc/aud_inc     one-cycle grant strobes per packet class
//   to_inc              one-cycle timeout strobe
//   vid_cnt/aud_cnt/to_cnt  counter values, saturating at all-ones
module gmii_tx_sched_stats #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vid_inc,
  input  logic             aud_inc,
  input  logic             to_inc,
  output logic [CNT_W-1:0] vid_cnt,
  output logic [CNT_W-1:0] aud_cnt,
  output logic [CNT_W-1:0] to_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vid_cnt <= '0;
      aud_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      vid_cnt <= sat_inc(vid_cnt, vid_inc);
      aud_cnt <= sat_inc(aud_cnt, aud_inc);
      to_cnt  <= sat_inc(to_cnt, to_inc);
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// Video/audio packet scheduler in front of the GMII frame builder.
// Latency: pkt_start one cycle after a request is seen in IDLE; next grant
//   GAP_CYC+1 cycles after pkt_done (or after a WAIT_DONE timeout).
// Backpressure: requests are levels sampled only while idle; the builder
//   throttles by delaying pkt_done, bounded by TIMEOUT_CYC.
//
// Optional feature macro: GMII_TX_SCHED_STATS_EN enables the statistics
// counters; without it the stats outputs are tied to 0 and stats_clr is
// ignored.
//
// Ports:
//   tx_clk, sys_rst          clock and synchronous active-high reset
//   vid_req, aud_req         level requests per packet class
//   aud_level                pending audio ADE count (urgency)
//   pkt_done                 builder pulse: frame fully sent
//   pkt_start, pkt_sel       start pulse and class (held until next start)
//   busy                     high from pkt_start through end of hold-off
//   timeout_err              one-cycle pulse when the builder never finished
//   stats_clr, vid_cnt, aud_cnt, to_cnt   statistics
module gmii_tx_sched
  import gmii_tx_sched_pkg::*;
#(
  parameter int unsigned VID_BURST_MAX = 4,
  parameter logic [3:0]  AUD_URGENT    = 4'd8,
  parameter logic [7:0]  GAP_CYC       = 8'd2,
  parameter int unsigned TIMEOUT_CYC   = 4096
) (
  input  logic        tx_clk,
  input  logic        sys_rst,
  input  logic        vid_req,
  input  logic        aud_req,
  input  logic [3:0]  aud_level,
  input  logic        pkt_done,
  output logic        pkt_start,
  output logic        pkt_sel,
  output logic        busy,
  output logic        timeout_err,
  input  logic        stats_clr,
  output logic [15:0] vid_cnt,
  output logic [15:0] aud_cnt,
  output logic [15:0] to_cnt
);

  localparam int unsigned RUN_W = $clog2(VID_BURST_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VID_BURST_MAX);
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [RUN_W-1:0] vid_run, vid_run_nxt;
  logic [TO_W-1:0]  to_ctr, to_ctr_nxt;
  logic [7:0]       gap, gap_nxt;
  logic             start_nxt;
  logic             sel_nxt;
  logic             to_err_nxt;
  logic             grant_vid;
  logic             grant_aud;
  logic             aud_wins;

  // Audio takes the slot when alone, when video has used up its burst
  // allowance, or when the audio backlog is urgent.
  assign aud_wins = aud_req &&
                    (!vid_req || (vid_run >= RUN_MAX) || (aud_level >= AUD_URGENT));

  always_comb begin
    state_nxt   = state;
    vid_run_nxt = vid_run;
    to_ctr_nxt  = to_ctr;
    gap_nxt     = gap;
    start_nxt   = 1'b0;
    sel_nxt     = pkt_sel;
    to_err_nxt  = 1'b0;
    grant_vid   = 1'b0;
    grant_aud   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (vid_req || aud_req) begin
          start_nxt  = 1'b1;
          to_ctr_nxt = '0;
          state_nxt  = ST_WAIT_DONE;
          if (aud_wins) begin
            sel_nxt     = SEL_AUDIO;
            grant_aud   = 1'b1;
            vid_run_nxt = '0;
          end else begin
            sel_nxt   = SEL_VIDEO;
            grant_vid = 1'b1;
            // Burst length only matters while audio is actually waiting.
            if (aud_req && (vid_run < RUN_MAX)) begin
              vid_run_nxt = vid_run + RUN_W'(1);
            end
          end
        end
      end

      ST_WAIT_DONE: begin
        if (pkt_done || (to_ctr == TO_LAST)) begin
          // A done on the last allowed cycle still counts as success.
          to_err_nxt = !pkt_done;
          to_ctr_nxt = '0;
          if (GAP_CYC == 8'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_HOLDOFF;
            gap_nxt   = GAP_CYC;
          end
        end else begin
          to_ctr_nxt = to_ctr + TO_W'(1);
        end
      end

      ST_HOLDOFF: begin
        if (gap <= 8'd1) begin
          gap_nxt   = 8'd0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap - 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      vid_run     <= '0;
      to_ctr      <= '0;
      gap         <= 8'd0;
      pkt_start   <= 1'b0;
      pkt_sel     <= SEL_VIDEO;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      vid_run     <= vid_run_nxt;
      to_ctr      <= to_ctr_nxt;
      gap         <= gap_nxt;
      pkt_start   <= start_nxt;
      pkt_sel     <= sel_nxt;
      timeout_err <= to_err_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef GMII_TX_SCHED_STATS_EN
  gmii_tx_sched_stats #(
    .CNT_W (16)
  ) u_stats (
    .clk     (tx_clk),
    .rst     (sys_rst),
    .clr     (stats_clr),
    .vid_inc (grant_vid),
    .aud_inc (grant_aud),
    .to_inc  (to_err_nxt),
    .vid_cnt (vid_cnt),
    .aud_cnt (aud_cnt),
    .to_cnt  (to_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = ^{stats_clr, grant_vid, grant_aud};
  assign vid_cnt = 16'd0;
  assign aud_cnt = 16'd0;
  assign to_cnt  = 16'd0;
`endif

endmodule
